// File: rtl/lzd_norm_pipe.sv
// Pipelined leading-zero/leading-one counter with a normalising left shifter.
// Count is resolved before stage 1; the shift runs between stages 1 and 2 (or before stage 1 when STAGES=1).
module lzd_norm_pipe #(
  parameter int N      = 64,
  parameter int CW     = $clog2(N) + 1,
  parameter int STAGES = 2,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_cnt,
  output logic             out_zero,
  output logic [N-1:0]     out_norm,
  output logic [TAG_W-1:0] out_tag
);

  logic [N-1:0]  scan_word;
  logic [CW-1:0] lead_cnt;
  logic          lead_zero;
  logic          found;

  // Mode 1 looks for the first zero, so invert and reuse the first-one search.
  assign scan_word = in_mode ? ~in_data : in_data;
  assign lead_zero = (scan_word == '0);

  always_comb begin
    lead_cnt = CW'(N);
    found    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && scan_word[i]) begin
        lead_cnt = CW'(N - 1 - i);
        found    = 1'b1;
      end
    end
  end

  logic [STAGES:1] v_reg;
  logic [STAGES:1] load;
  logic [STAGES:1] vld_src;
  logic [CW-1:0]    cnt_reg  [1:STAGES];
  logic             zero_reg [1:STAGES];
  logic [N-1:0]     data_reg [1:STAGES];
  logic [TAG_W-1:0] tag_reg  [1:STAGES];
  logic [CW-1:0]    cnt_src  [1:STAGES];
  logic             zero_src [1:STAGES];
  logic [N-1:0]     data_src [1:STAGES];
  logic [TAG_W-1:0] tag_src  [1:STAGES];

  genvar gi;
  generate
    for (gi = 1; gi <= STAGES; gi++) begin : g_src
      if (gi == 1) begin : g_head
        assign vld_src[gi]  = in_valid;
        assign cnt_src[gi]  = lead_cnt;
        assign zero_src[gi] = lead_zero;
        assign tag_src[gi]  = in_tag;
        // Stage 1 carries the raw word unless it is also the last stage.
        assign data_src[gi] = (STAGES == 1) ? (in_data << lead_cnt) : in_data;
      end else begin : g_tail
        assign vld_src[gi]  = v_reg[gi-1];
        assign cnt_src[gi]  = cnt_reg[gi-1];
        assign zero_src[gi] = zero_reg[gi-1];
        assign tag_src[gi]  = tag_reg[gi-1];
        assign data_src[gi] = (gi == 2) ? (data_reg[gi-1] << cnt_reg[gi-1])
                                        : data_reg[gi-1];
      end
    end
  endgenerate

  // A stage may load when empty or when everything below it can move; this
  // collapses bubbles even while the output is stalled.
  always_comb begin : ready_chain
    logic down;
    load = '0;
    down = out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      load[k] = ~v_reg[k] | down;
      down    = load[k];
    end
  end

  assign in_ready = load[1] & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_reg <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        cnt_reg[k]  <= '0;
        zero_reg[k] <= 1'b0;
        data_reg[k] <= '0;
        tag_reg[k]  <= '0;
      end
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (load[k]) begin
          v_reg[k] <= vld_src[k];
          if (vld_src[k]) begin
            cnt_reg[k]  <= cnt_src[k];
            zero_reg[k] <= zero_src[k];
            data_reg[k] <= data_src[k];
            tag_reg[k]  <= tag_src[k];
          end
        end
      end
    end
  end

  assign out_valid = v_reg[STAGES];
  assign out_cnt   = cnt_reg[STAGES];
  assign out_zero  = zero_reg[STAGES];
  assign out_norm  = data_reg[STAGES];
  assign out_tag   = tag_reg[STAGES];

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// Bench for lzd_norm_pipe: four builds (N=16/S=2, N=12/S=2, N=16/S=1, N=16/S=4)
// checked against an arithmetic reference model and a per-build FIFO scoreboard.
module tb_lzd_norm_pipe;

  typedef struct {
    logic [4:0]  cnt;
    logic        zero;
    logic [15:0] norm;
    logic [7:0]  tag;
    int          acc;
    bit          lat;
    bit          dir;
    logic [4:0]  dcnt;
    logic        dzero;
    logic [15:0] dnorm;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] din = '0;
  logic        mode = 1'b0;
  logic [7:0]  tagin = '0;
  logic [3:0]  vld = '0;
  logic [3:0]  rdy, ov, oz;
  logic [4:0]  oc [4];
  logic [15:0] on [4];
  logic [7:0]  ot [4];
  logic [11:0] norm12;
  logic        out_ready;
  logic        orand = 1'b1;
  logic        ready_force = 1'b1;
  logic        rand_bp = 1'b0;

  assign out_ready = rand_bp ? orand : ready_force;
  assign on[1] = {4'h0, norm12};

  lzd_norm_pipe #(.N(16), .STAGES(2), .TAG_W(8)) u16 (
    .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_data(din), .in_mode(mode), .in_tag(tagin), .out_valid(ov[0]),
    .out_ready(out_ready), .out_cnt(oc[0]), .out_zero(oz[0]),
    .out_norm(on[0]), .out_tag(ot[0]));

  lzd_norm_pipe #(.N(12), .STAGES(2), .TAG_W(8)) u12 (
    .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_data(din[11:0]), .in_mode(mode), .in_tag(tagin), .out_valid(ov[1]),
    .out_ready(out_ready), .out_cnt(oc[1]), .out_zero(oz[1]),
    .out_norm(norm12), .out_tag(ot[1]));

  lzd_norm_pipe #(.N(16), .STAGES(1), .TAG_W(8)) u1 (
    .clk(clk), .reset(reset), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_data(din), .in_mode(mode), .in_tag(tagin), .out_valid(ov[2]),
    .out_ready(out_ready), .out_cnt(oc[2]), .out_zero(oz[2]),
    .out_norm(on[2]), .out_tag(ot[2]));

  lzd_norm_pipe #(.N(16), .STAGES(4), .TAG_W(8)) u4 (
    .clk(clk), .reset(reset), .in_valid(vld[3]), .in_ready(rdy[3]),
    .in_data(din), .in_mode(mode), .in_tag(tagin), .out_valid(ov[3]),
    .out_ready(out_ready), .out_cnt(oc[3]), .out_zero(oz[3]),
    .out_norm(on[3]), .out_tag(ot[3]));

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   sent [4] = '{0, 0, 0, 0};
  int   acc_cnt [4] = '{0, 0, 0, 0};
  bit   seen [4] = '{0, 0, 0, 0};
  bit   mon_en = 0, rst_seen = 0, free_run = 1, thru_chk = 0, final_chk = 0, dir_en = 0;
  logic [4:0]  dcnt = '0;
  logic        dzero = 1'b0;
  logic [15:0] dnorm = '0;
  exp_t q [4][$];
  exp_t f;
  logic [4:0]  mc;
  logic        mz;
  logic [15:0] mn;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    orand = ($urandom_range(0, 3) != 0);
  end

  function automatic int stg_of(input int k);
    case (k)
      2: return 1;
      3: return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int n_of(input int k);
    return (k == 1) ? 12 : 16;
  endfunction

  // Reference: leading run = n - bit length of the scanned word.
  function automatic void model(input logic [15:0] d, input logic m, input int n,
                                output logic [4:0] c, output logic z, output logic [15:0] nm);
    int mask, dd, w, cc;
    mask = (1 << n) - 1;
    dd   = int'(d) & mask;
    w    = (m ? ~dd : dd) & mask;
    cc   = n - $clog2(w + 1);
    c    = 5'(cc);
    z    = (w == 0);
    nm   = 16'((dd << cc) & mask);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 4; k++) begin
        check_eq($sformatf("u%0d.in_ready", k), 32'(rdy[k]),
                 32'(!reset && (q[k].size() < stg_of(k) || out_ready)));
        if (rst_seen) begin
          check_eq($sformatf("u%0d.rst_valid", k), 32'(ov[k]), 32'd0);
          check_eq($sformatf("u%0d.rst_cnt", k), 32'(oc[k]), 32'd0);
          check_eq($sformatf("u%0d.rst_zero", k), 32'(oz[k]), 32'd0);
          check_eq($sformatf("u%0d.rst_norm", k), 32'(on[k]), 32'd0);
          check_eq($sformatf("u%0d.rst_tag", k), 32'(ot[k]), 32'd0);
        end
        if (q[k].size() == 0) begin
          check_eq($sformatf("u%0d.idle_valid", k), 32'(ov[k]), 32'd0);
        end else begin
          if (thru_chk && k == 0) check_eq("u0.throughput", 32'(ov[k]), 32'd1);
          if (ov[k]) begin
            f = q[k][0];
            if (!seen[k]) begin
              seen[k] = 1;
              if (f.lat) check_eq($sformatf("u%0d.latency", k), 32'(cyc - f.acc), 32'(stg_of(k)));
            end
            check_eq($sformatf("u%0d.cnt", k), 32'(oc[k]), 32'(f.cnt));
            check_eq($sformatf("u%0d.zero", k), 32'(oz[k]), 32'(f.zero));
            check_eq($sformatf("u%0d.norm", k), 32'(on[k]), 32'(f.norm));
            check_eq($sformatf("u%0d.tag", k), 32'(ot[k]), 32'(f.tag));
            if (f.dir) begin
              check_eq($sformatf("u%0d.dir_cnt", k), 32'(oc[k]), 32'(f.dcnt));
              check_eq($sformatf("u%0d.dir_zero", k), 32'(oz[k]), 32'(f.dzero));
              check_eq($sformatf("u%0d.dir_norm", k), 32'(on[k]), 32'(f.dnorm));
            end
            if (out_ready) begin
              void'(q[k].pop_front());
              seen[k] = 0;
            end
          end
        end
        if (reset) begin
          q[k].delete();
          seen[k] = 0;
        end else if (vld[k] && rdy[k]) begin
          model(din, mode, n_of(k), mc, mz, mn);
          f.cnt = mc; f.zero = mz; f.norm = mn; f.tag = tagin;
          f.acc = cyc; f.lat = free_run; f.dir = dir_en;
          f.dcnt = dcnt; f.dzero = dzero; f.dnorm = dnorm;
          q[k].push_back(f);
          acc_cnt[k]++;
        end
        if (final_chk) check_eq($sformatf("u%0d.leftover", k), 32'(q[k].size()), 32'd0);
      end
    end
    rst_seen = reset;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic update_vld();
    for (int k = 0; k < 4; k++) vld[k] = (acc_cnt[k] < sent[k]);
  endtask

  task automatic send(input logic [15:0] d, input logic m, input logic [7:0] t, input logic [3:0] mask);
    int guard;
    din = d; mode = m; tagin = t;
    for (int k = 0; k < 4; k++) if (mask[k]) sent[k]++;
    update_vld();
    guard = 0;
    while (vld != 4'h0) begin
      step();
      update_vld();
      guard++;
      if (guard > 300) begin
        $display("FAIL send_timeout: word 0x%0h not accepted, pending 0x%0h", d, vld);
        $fatal(1, "input handshake stuck");
      end
    end
  endtask

  task automatic send_dir(input logic [15:0] d, input logic m, input logic [7:0] t, input logic [3:0] mask,
                          input logic [4:0] c, input logic z, input logic [15:0] n);
    dir_en = 1; dcnt = c; dzero = z; dnorm = n;
    send(d, m, t, mask);
    dir_en = 0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] r;
    case ($urandom_range(0, 4))
      0: r = 16'($urandom);
      1: r = 16'hFFFF >> $urandom_range(0, 16);
      2: r = ~(16'hFFFF >> $urandom_range(0, 16));
      3: r = 16'h0001 << $urandom_range(0, 15);
      default: r = 16'($urandom) >> $urandom_range(0, 15);
    endcase
    return r;
  endfunction

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && guard < 100) begin
      step();
      guard++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1;
    step();
    reset = 0;

    // Directed words with fixed expectations.
    send_dir(16'h0100, 1'b0, 8'h05, 4'b0001, 5'd7, 1'b0, 16'h8000);
    send_dir(16'h0000, 1'b0, 8'h06, 4'b0001, 5'd16, 1'b1, 16'h0000);
    send_dir(16'hFFFF, 1'b1, 8'h07, 4'b0001, 5'd16, 1'b1, 16'h0000);
    send_dir(16'hF0F0, 1'b1, 8'h08, 4'b0001, 5'd4, 1'b0, 16'h0F00);
    send_dir(16'h0001, 1'b0, 8'h09, 4'b0010, 5'd11, 1'b0, 16'h0800);
    send_dir(16'h0800, 1'b0, 8'h0A, 4'b0010, 5'd0, 1'b0, 16'h0800);
    send_dir(16'h0FFF, 1'b1, 8'h0B, 4'b0010, 5'd12, 1'b1, 16'h0000);
    wait_drain();
    send(16'h0040, 1'b0, 8'h0C, 4'b1100);
    wait_drain();

    // Back-to-back stream into the N=16/S=2 build with an output stall.
    free_run = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_word(), 1'($urandom_range(0, 1)), 8'(i), 4'b0001);
      end
      begin
        repeat (2) step();
        ready_force = 0;
        repeat (4) step();
        ready_force = 1;
        thru_chk = 1;
        for (int g = 0; g < 40 && q[0].size() != 0; g++) step();
        thru_chk = 0;
      end
    join
    wait_drain();

    // Reset with words in flight, junk presented during reset, then a clean word.
    free_run = 1;
    send(16'h1234, 1'b0, 8'h21, 4'b1111);
    send(16'hFF0F, 1'b1, 8'h22, 4'b1111);
    reset = 1;
    din = 16'hBEEF;
    vld = 4'hF;
    step();
    reset = 0;
    vld = 4'h0;
    send(16'h0300, 1'b0, 8'h23, 4'b1111);
    wait_drain();

    // Random words at full output rate, then under random backpressure.
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(rand_word(), 1'($urandom_range(0, 1)), 8'($urandom), 4'b1111);
    end
    wait_drain();
    free_run = 0;
    rand_bp = 1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(rand_word(), 1'($urandom_range(0, 1)), 8'($urandom), 4'b1111);
    end
    rand_bp = 0;
    ready_force = 1;
    wait_drain();

    final_chk = 1;
    @(negedge clk);
    #1;
    final_chk = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
